// File: rtl/btn_debounce_strobe.sv
// Button/switch conditioner: 2-FF synchronizer, stability-qualified FSM, and
// registered debounced level with single-cycle rise/fall strobes.
module btn_debounce_strobe #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic db_level,
  output logic rise_pulse,
  output logic fall_pulse
);

  typedef enum logic [1:0] {
    LOW,
    WAIT_HIGH,
    HIGH,
    WAIT_LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_level_q, db_level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Strobes default low so they last exactly one cycle after an accepting edge.
  always_comb begin
    s1_d       = raw_in;
    s2_d       = s1_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    db_level_d = db_level_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;

    case (state_q)
      LOW: begin
        if (s2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2_q) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = HIGH;
          cnt_d      = '0;
          db_level_d = 1'b1;
          rise_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s2_q) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = LOW;
          cnt_d      = '0;
          db_level_d = 1'b0;
          fall_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      state_q    <= LOW;
      cnt_q      <= '0;
      db_level_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      db_level_q <= db_level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  assign db_level   = db_level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_btn_debounce_strobe.sv
// Bench for btn_debounce_strobe: vector table, directed corner sequences and
// random bounce traffic checked against a sample-window reference model.
module tb_btn_debounce_strobe;

  localparam int STABLE = 4;
  localparam int CNT_W  = 4;
  localparam int NVEC   = 29;

  logic       clk = 1'b0;
  logic       rst;
  logic       raw_in;
  logic       db_level, rise_pulse, fall_pulse;
  logic [7:0] pattern;
  logic [7:0] flop_q;

  int checks = 0;
  int passes = 0;

  // Reference model: the level flips once the last STABLE synchronized
  // samples all disagree with it.
  logic       m_p1, m_p2, m_level, m_rise, m_fall;
  logic [7:0] m_q;
  bit         m_hist[$];

  typedef struct {
    logic raw;
    logic rst;
    logic level;
    logic rise;
    logic fall;
  } vec_t;
  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  btn_debounce_strobe #(.STABLE_CYCLES(STABLE), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .db_level  (db_level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  // Downstream enable flop fed by the rise strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flop_q <= 8'd0;
    else if (rise_pulse) flop_q <= pattern;
  end

  task automatic modelReset();
    m_p1 = 1'b0; m_p2 = 1'b0; m_level = 1'b0;
    m_rise = 1'b0; m_fall = 1'b0; m_q = 8'd0;
    m_hist.delete();
  endtask

  task automatic modelStep();
    logic seen;
    bit   all_diff;
    if (!rst) begin
      modelReset();
    end else begin
      seen = m_p2;
      m_p2 = m_p1;
      m_p1 = raw_in;
      if (m_rise) m_q = pattern;
      m_rise = 1'b0;
      m_fall = 1'b0;
      m_hist.push_back(seen);
      if (m_hist.size() > STABLE) m_hist.delete(0);
      if (m_hist.size() == STABLE) begin
        all_diff = 1'b1;
        foreach (m_hist[i]) if (m_hist[i] == m_level) all_diff = 1'b0;
        if (all_diff) begin
          m_level = ~m_level;
          if (m_level) m_rise = 1'b1;
          else m_fall = 1'b1;
        end
      end
    end
  endtask

  task automatic compareVal(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic checkOutput(input string tag);
    compareVal({tag, "_level"}, int'(db_level), int'(m_level));
    compareVal({tag, "_rise"}, int'(rise_pulse), int'(m_rise));
    compareVal({tag, "_fall"}, int'(fall_pulse), int'(m_fall));
    compareVal({tag, "_q"}, int'(flop_q), int'(m_q));
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic applyStimulus(input logic raw, input logic r, input string tag);
    raw_in  = raw;
    rst     = r;
    pattern = pattern + 8'd1;
    if (!r) modelReset();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    int rise_cnt;
    int rise_at;
    int rel_rise;
    int hold;
    logic rv;

    for (int i = 0; i < NVEC; i++) begin
      vecs[i].raw   = (i <= 7) || (i >= 11 && i <= 16) || (i >= 21);
      vecs[i].rst   = 1'b1;
      vecs[i].level = (i >= 5 && i <= 21) || (i >= 26);
      vecs[i].rise  = (i == 5) || (i == 26);
      vecs[i].fall  = (i == 22);
    end

    rst = 1'b0; raw_in = 1'b0; pattern = 8'd0;
    modelReset();
    @(negedge clk);

    // Reset hold with a toggling input.
    for (int i = 0; i < 8; i++) applyStimulus(logic'(i % 2), 1'b0, "rst_hold");

    // Clean press, short and exact-length low excursions, re-press.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].raw, vecs[i].rst, "vec");
      compareVal($sformatf("tbl%0d_level", i), int'(db_level), int'(vecs[i].level));
      compareVal($sformatf("tbl%0d_rise", i), int'(rise_pulse), int'(vecs[i].rise));
      compareVal($sformatf("tbl%0d_fall", i), int'(fall_pulse), int'(vecs[i].fall));
    end

    // Asynchronous reset assertion while the level is high.
    #2 rst = 1'b0;
    modelReset();
    #1 checkOutput("async_drop");
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, "rst_low");
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, "settle0");

    // Bounce train then settle high.
    rise_cnt = 0; rise_at = -1;
    for (int i = 0; i < 32; i++) begin
      applyStimulus((i < 20) ? logic'(((i / 2) % 2) == 0) : 1'b1, 1'b1, "train");
      if (rise_pulse) begin
        rise_cnt++;
        rise_at = i;
      end
    end
    compareVal("train_rises", rise_cnt, 1);
    compareVal("train_latency", rise_at, 25);

    // Reset in the middle of a qualifying count.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, "go_low");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, "midcnt");
    compareVal("midcnt_cnt", int'(dut.cnt_q), 2);
    applyStimulus(1'b1, 1'b0, "midcnt_rst");
    compareVal("midcnt_cnt_cleared", int'(dut.cnt_q), 0);
    rel_rise = -1;
    for (int j = 1; j <= 10; j++) begin
      applyStimulus(1'b1, 1'b1, "release");
      if (rise_pulse && rel_rise < 0) rel_rise = j;
    end
    compareVal("release_latency", rel_rise, 6);

    // Random bounce traffic with occasional resets.
    for (int n = 0; n < 150; n++) begin
      rv   = logic'($urandom_range(0, 1));
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        applyStimulus(rv, ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1, "rand");
        compareVal("rand_excl", int'(rise_pulse & fall_pulse), 0);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
